// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: registered driver for DIGITS common-anode 8-segment LEDs.
//   Captures a value on iLoad. It shows the value either as raw hex nibbles or
//   as decimal, using a serial double-dabble conversion of one bit per cycle.
//   It supports leading-zero blanking, per-digit decimal points, per-digit
//   blink and a global PWM brightness control.
// Ports:
//   iClk, iRst        clock (rising edge), asynchronous active-high reset
//   iLoad             1-cycle strobe capturing iNum/iDec/iDp/iBlank0/iBlink
//   iNum[4*DIGITS]    hex nibbles or unsigned binary (iDec=1)
//   iDec              convert binary to decimal
//   iDp[DIGITS]       decimal point per digit
//   iBlank0           leading-zero blanking enable
//   iBlink[DIGITS]    blink enable per digit
//   iBright[PWM_BITS] brightness, sampled continuously
//   oHex[8*DIGITS]    active-low segments, digit k in [8k+7:8k], bit7 = dp
//   oBusy             decimal conversion in progress
//   oOvf              last committed decimal value did not fit

// Per-digit glyph decoder (combinational).
module seg_digit (
    input  logic [3:0] nib,
    input  logic       dp,
    input  logic       blank,
    input  logic       ovf,
    input  logic       off,
    output logic [7:0] seg
);
    logic [6:0] glyph;

    always_comb begin
        glyph = 7'h7F;
        case (nib)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h27;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
            default: glyph = 7'h7F;
        endcase
        // Blink-off wins over everything. Overflow ignores blanking.
        if (off || (blank && !ovf))
            seg = 8'hFF;
        else if (ovf)
            seg = {~dp, 7'h3F};
        else
            seg = {~dp, glyph};
    end
endmodule

module seg_display_ctrl #(
    parameter int DIGITS    = 8,
    parameter int BLINK_DIV = 12500000,
    parameter int PWM_BITS  = 4
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iLoad,
    input  logic [4*DIGITS-1:0]   iNum,
    input  logic                  iDec,
    input  logic [DIGITS-1:0]     iDp,
    input  logic                  iBlank0,
    input  logic [DIGITS-1:0]     iBlink,
    input  logic [PWM_BITS-1:0]   iBright,
    output logic [8*DIGITS-1:0]   oHex,
    output logic                  oBusy,
    output logic                  oOvf
);
    localparam int NW = 4 * DIGITS;
    localparam int IW = $clog2(NW);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;
    state_t state, state_nxt;

    // Conversion working set
    logic [IW-1:0]            iter;
    logic [NW-1:0]            bin, bcd, bcd_adj, bcd_nxt;
    logic                     conv_ovf, shout, last_iter;
    logic [DIGITS-1:0]        dp_p, blink_p;
    logic                     blank_p;

    // Committed display state
    logic [DIGITS-1:0][3:0]   disp;
    logic [DIGITS-1:0]        dp_r, blink_r;
    logic                     blank_r, ovf_r;

    logic [PWM_BITS-1:0]      pwm_cnt;
    logic [BW-1:0]            blink_cnt;
    logic                     blink_ph;

    logic [DIGITS-1:0]        digit_blank;
    logic                     run;
    logic [DIGITS-1:0][7:0]   seg_w;

    assign oBusy = (state == CONV);
    assign oOvf  = ovf_r;

    always_comb begin
        state_nxt = state;
        last_iter = (iter == IW'(NW - 1));
        case (state)
            IDLE:    if (iLoad && iDec) state_nxt = CONV;
            CONV:    if (last_iter) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift in the next
    // binary bit. A 1 leaving the top digit means the value needs more than DIGITS digits.
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < DIGITS; k++)
            if (bcd[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        bcd_nxt = {bcd_adj[NW-2:0], bin[NW-1]};
        shout   = bcd_adj[NW-1];
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state    <= IDLE;
            iter     <= '0;
            bin      <= '0;
            bcd      <= '0;
            conv_ovf <= 1'b0;
            dp_p     <= '0;
            blink_p  <= '0;
            blank_p  <= 1'b0;
            disp     <= '0;
            dp_r     <= '0;
            blink_r  <= '0;
            blank_r  <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (iLoad) begin
                    if (iDec) begin
                        bin      <= iNum;
                        bcd      <= '0;
                        iter     <= '0;
                        conv_ovf <= 1'b0;
                        dp_p     <= iDp;
                        blank_p  <= iBlank0;
                        blink_p  <= iBlink;
                    end else begin
                        disp     <= iNum;
                        ovf_r    <= 1'b0;
                        dp_r     <= iDp;
                        blank_r  <= iBlank0;
                        blink_r  <= iBlink;
                    end
                end
                CONV: begin
                    bin      <= bin << 1;
                    bcd      <= bcd_nxt;
                    iter     <= iter + 1'b1;
                    conv_ovf <= conv_ovf | shout;
                    if (last_iter) begin
                        disp    <= bcd_nxt;
                        ovf_r   <= conv_ovf | shout;
                        dp_r    <= dp_p;
                        blank_r <= blank_p;
                        blink_r <= blink_p;
                    end
                end
                default: ;
            endcase
        end
    end

    // Leading-zero blanking runs from the top digit down. It stops at the first
    // nonzero digit or at the first digit with its dp lit. Digit 0 always shows.
    always_comb begin
        digit_blank = '0;
        run = blank_r & ~ovf_r;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run = run && (disp[k] == 4'd0) && !dp_r[k];
            digit_blank[k] = run;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        seg_digit u_dig (
            .nib   (disp[g]),
            .dp    (dp_r[g]),
            .blank (digit_blank[g]),
            .ovf   (ovf_r),
            .off   (blink_r[g] & blink_ph),
            .seg   (seg_w[g])
        );
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
            oHex      <= '1;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            oHex <= (pwm_cnt <= iBright) ? seg_w : '1;
        end
    end
endmodule

// File: tb/tb_seg_display_ctrl.sv
module tb_seg_display_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [31:0] num = '0;
    logic        dec = 1'b0;
    logic [7:0]  dp = '0;
    logic        blank0 = 1'b0;
    logic [7:0]  blink = '0;
    logic [3:0]  bright = 4'hF;
    logic [63:0] hex;
    logic        busy, ovf;

    int tests = 0;
    int fails = 0;

    seg_display_ctrl #(.DIGITS(8), .BLINK_DIV(4), .PWM_BITS(4)) dut (
        .iClk(clk), .iRst(rst), .iLoad(load), .iNum(num), .iDec(dec), .iDp(dp),
        .iBlank0(blank0), .iBlink(blink), .iBright(bright),
        .oHex(hex), .oBusy(busy), .oOvf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] num;
        logic        dec;
        logic [7:0]  dp;
        logic        blank0;
        logic [63:0] exp_hex;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[13];

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Strobe one load, then wait out any conversion and one more edge for oHex.
    task automatic do_load(input logic [31:0] n, input logic d, input logic [7:0] p,
                           input logic b, input logic [7:0] bl, output int bcnt);
        @(negedge clk);
        num = n; dec = d; dp = p; blank0 = b; blink = bl; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        bcnt = 0;
        while (busy && bcnt < 100) begin
            @(posedge clk); #1;
            bcnt++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int bcnt, on_cnt, bad, trans, last_t, bad_int;
        logic [7:0] s[24];

        vecs[0]  = '{32'h0012ABCD, 1'b0, 8'h00, 1'b0, 64'hC0C0F9A48883A7A1, 1'b0};
        vecs[1]  = '{32'h0012ABCD, 1'b0, 8'h00, 1'b1, 64'hFFFFF9A48883A7A1, 1'b0};
        vecs[2]  = '{32'h0012ABCD, 1'b0, 8'h80, 1'b1, 64'h40C0F9A48883A7A1, 1'b0};
        vecs[3]  = '{32'd12345,     1'b1, 8'h00, 1'b1, 64'hFFFFFFF9A4B09992, 1'b0};
        vecs[4]  = '{32'd100000000, 1'b1, 8'h00, 1'b1, 64'hBFBFBFBFBFBFBFBF, 1'b1};
        vecs[5]  = '{32'h00000000, 1'b0, 8'h00, 1'b0, 64'hC0C0C0C0C0C0C0C0, 1'b0};
        vecs[6]  = '{32'd99999999,  1'b1, 8'h00, 1'b0, 64'h9090909090909090, 1'b0};
        vecs[7]  = '{32'd0,         1'b1, 8'h00, 1'b1, 64'hFFFFFFFFFFFFFFC0, 1'b0};
        vecs[8]  = '{32'hFFFFFFFF, 1'b0, 8'h01, 1'b1, 64'h8E8E8E8E8E8E8E0E, 1'b0};
        vecs[9]  = '{32'h00000000, 1'b0, 8'h10, 1'b1, 64'hFFFFFF40C0C0C0C0, 1'b0};
        vecs[10] = '{32'hFFFFFFFF, 1'b1, 8'h01, 1'b1, 64'hBFBFBFBFBFBFBF3F, 1'b1};
        vecs[11] = '{32'h01234567, 1'b0, 8'h00, 1'b1, 64'hFFF9A4B0999282F8, 1'b0};
        vecs[12] = '{32'd10000000,  1'b1, 8'h00, 1'b1, 64'hF9C0C0C0C0C0C0C0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check64("rst_hex", hex, {8{8'hFF}});
        check_int("rst_busy", busy, 0);
        check_int("rst_ovf", ovf, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check64("post_rst_hex", hex, {8{8'hC0}});

        // Table-driven loads
        for (int i = 0; i < 13; i++) begin
            do_load(vecs[i].num, vecs[i].dec, vecs[i].dp, vecs[i].blank0, 8'h00, bcnt);
            check_int($sformatf("vec%0d_busy", i), bcnt, vecs[i].dec ? 32 : 0);
            check64($sformatf("vec%0d_hex", i), hex, vecs[i].exp_hex);
            check_int($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
        end

        // Blink on digit 0: toggles between A1 and FF every 4 cycles
        do_load(32'h0012ABCD, 1'b0, 8'h00, 1'b0, 8'h01, bcnt);
        bad = 0;
        for (int t = 0; t < 24; t++) begin
            s[t] = hex[7:0];
            if (hex[63:8] !== 56'hC0C0F9A48883A7) bad++;
            if (s[t] !== 8'hA1 && s[t] !== 8'hFF) bad++;
            @(posedge clk); #1;
        end
        check_int("blink_values", bad, 0);
        trans = 0; last_t = -1; bad_int = 0;
        for (int t = 1; t < 24; t++) begin
            if (s[t] !== s[t-1]) begin
                if (last_t >= 0 && (t - last_t) != 4) bad_int++;
                last_t = t;
                trans++;
            end
        end
        check_int("blink_period", bad_int, 0);
        check_int("blink_enough_trans", (trans >= 5) ? 1 : 0, 1);

        // PWM duty
        do_load(32'h0012ABCD, 1'b0, 8'h00, 1'b0, 8'h00, bcnt);
        @(negedge clk); bright = 4'd3;
        @(posedge clk); #1;
        on_cnt = 0; bad = 0;
        for (int t = 0; t < 32; t++) begin
            if (hex === 64'hC0C0F9A48883A7A1) on_cnt++;
            else if (hex !== {8{8'hFF}}) bad++;
            @(posedge clk); #1;
        end
        check_int("pwm3_on", on_cnt, 8);
        check_int("pwm3_bad", bad, 0);
        @(negedge clk); bright = 4'd0;
        @(posedge clk); #1;
        on_cnt = 0;
        for (int t = 0; t < 32; t++) begin
            if (hex === 64'hC0C0F9A48883A7A1) on_cnt++;
            @(posedge clk); #1;
        end
        check_int("pwm0_on", on_cnt, 2);
        @(negedge clk); bright = 4'hF;

        // Reset in the middle of a conversion, with overflow set beforehand
        do_load(32'd100000000, 1'b1, 8'h00, 1'b0, 8'h00, bcnt);
        check_int("pre_abort_ovf", ovf, 1);
        @(negedge clk);
        num = 32'd12345; dec = 1'b1; blank0 = 1'b1; dp = 8'h00; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check64("abort_hex", hex, {8{8'hFF}});
        check_int("abort_busy", busy, 0);
        check_int("abort_ovf", ovf, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check64("abort_release_hex", hex, {8{8'hC0}});

        // Second strobe during CONV must be ignored; display holds until commit
        @(negedge clk);
        num = 32'd12345; dec = 1'b1; blank0 = 1'b1; dp = 8'h00; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        bcnt = 0;
        while (busy && bcnt < 100) begin
            if (bcnt == 5) begin
                load = 1'b1; num = 32'h0012ABCD; dec = 1'b0;
            end else begin
                load = 1'b0;
            end
            if (bcnt == 15) check64("conv_hold_hex", hex, {8{8'hC0}});
            @(posedge clk); #1;
            bcnt++;
        end
        load = 1'b0;
        check_int("ignore_busy", bcnt, 32);
        @(posedge clk); #1;
        check64("ignore_hex", hex, 64'hFFFFFFF9A4B09992);
        check_int("ignore_ovf", ovf, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
